// File: rtl/prod_arb_if.sv
// Producer-to-arbiter bundle: N request lanes in, one registered output channel out.
interface prod_arb_if #(
  parameter int SW = 2,
  parameter int W  = 8
) ();
  localparam int N = 1 << SW;

  logic [N-1:0]   req_val;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_rdy;
  logic           val;
  logic [W-1:0]   data;
  logic [SW-1:0]  src;
  logic           busy;

  modport master (output req_val, req_data, input req_rdy, val, data, src, busy);
  modport slave  (input req_val, req_data, output req_rdy, val, data, src, busy);
endinterface

// File: rtl/prod_arb.sv
// Round-robin arbiter with burst hold: one grant per cycle, accepted word registered
// onto a single val/data/src channel feeding the accumulator.
module prod_arb #(
  parameter int SW    = 2,
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic     clk,
  input  logic     rst_b,
  prod_arb_if.slave bus
);
  localparam int N = 1 << SW;
  localparam logic [3:0] BURST_C = 4'(BURST);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        r_state;
  logic [SW-1:0] r_ptr, r_owner, r_src;
  logic [3:0]    r_cnt;
  logic          r_val, r_busy;
  logic [W-1:0]  r_data;

  logic          w_keep, w_found, w_gnt, w_nxt_hold;
  logic [SW-1:0] w_base, w_idx, w_win, w_gidx, w_owner_nx;

  always_comb begin
    w_owner_nx = r_owner + 1'b1;
    w_keep     = (r_state == HOLD) && bus.req_val[r_owner];
    // A dropped owner hands priority to its neighbour in the same cycle.
    w_base     = (r_state == HOLD) ? w_owner_nx : r_ptr;
    w_found    = 1'b0;
    w_win      = '0;
    w_idx      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = w_base + SW'(k);
      if (bus.req_val[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_gnt      = w_keep | w_found;
    w_gidx     = w_keep ? r_owner : w_win;
    w_nxt_hold = w_keep ? (r_cnt + 4'd1 != BURST_C) : (w_found && BURST != 1);
  end

  assign bus.req_rdy = w_gnt ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
  assign bus.val     = r_val;
  assign bus.data    = r_data;
  assign bus.src     = r_src;
  assign bus.busy    = r_busy;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_val   <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_val  <= w_gnt;
      r_busy <= w_nxt_hold;
      if (w_gnt) begin
        r_data <= bus.req_data[w_gidx*W +: W];
        r_src  <= w_gidx;
      end
      if (w_keep) begin
        if (r_cnt + 4'd1 == BURST_C) begin
          r_state <= IDLE;
          r_ptr   <= w_owner_nx;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + 4'd1;
        end
      end else if (w_found) begin
        r_owner <= w_win;
        r_cnt   <= 4'd1;
        if (BURST == 1) begin
          r_state <= IDLE;
          r_ptr   <= w_win + 1'b1;
        end else begin
          r_state <= HOLD;
          if (r_state == HOLD) r_ptr <= w_owner_nx;
        end
      end else if (r_state == HOLD) begin
        r_state <= IDLE;
        r_ptr   <= w_owner_nx;
        r_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prod_arb.sv
// Directed bench for prod_arb: stimulus pushes expected per-cycle output into a queue,
// a negedge monitor pops and compares against the registered channel.
module tb_prod_arb;
  localparam int SW = 2, W = 8, N = 4, BURST = 4;

  logic clk = 1'b1;
  logic rst_b = 1'b0;
  logic [N-1:0][W-1:0] din;

  prod_arb_if #(.SW(SW), .W(W)) bus ();
  prod_arb #(.SW(SW), .W(W), .BURST(BURST)) dut (.clk(clk), .rst_b(rst_b), .bus(bus.slave));

  assign bus.req_data = din;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic          v;
    logic [W-1:0]  d;
    logic [SW-1:0] s;
    logic          b;
  } exp_t;

  exp_t q[$];
  int checks = 0, fails = 0, sum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] oh2i(input logic [N-1:0] oh);
    oh2i = '0;
    for (int i = 0; i < N; i++) if (oh[i]) oh2i = SW'(i);
  endfunction

  // Output registered at the next edge is derived from the hand-written grant vector.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rdy, input logic b);
    exp_t e;
    bus.req_val = v;
    #1;
    chk("req_rdy", 32'(bus.req_rdy), 32'(rdy));
    e.due = cyc + 1;
    e.v   = |rdy;
    e.s   = oh2i(rdy);
    e.d   = din[oh2i(rdy)];
    e.b   = b;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    #2 rst_b = 1'b0;
    #1;
    chk("rst_val",  32'(bus.val),  0);
    chk("rst_data", 32'(bus.data), 0);
    chk("rst_src",  32'(bus.src),  0);
    chk("rst_busy", 32'(bus.busy), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_b) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("val",  32'(bus.val),  32'(e.v));
        chk("busy", 32'(bus.busy), 32'(e.b));
        if (e.v) begin
          chk("data", 32'(bus.data), 32'(e.d));
          chk("src",  32'(bus.src),  32'(e.s));
          sum += int'(bus.data);
        end
      end else begin
        chk("val_unexpected", 32'(bus.val), 0);
      end
    end
  end

  initial begin
    din = {8'd4, 8'd3, 8'd2, 8'd1};
    bus.req_val = 4'b1111;
    #24;
    chk("reset_val",  32'(bus.val),  0);
    chk("reset_data", 32'(bus.data), 0);
    chk("reset_src",  32'(bus.src),  0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_rdy",  32'(bus.req_rdy), 32'h1);
    #1 rst_b = 1'b1;

    // Full contention: four-word bursts rotating 0,1,2,3.
    for (int k = 0; k < 16; k++) step(4'b1111, 4'(1 << (k / 4)), (k % 4) != 3);
    step(4'b0000, 4'b0000, 1'b0);
    #1 chk("sum_full", sum, 40);
    @(negedge clk);

    // Sole requester keeps winning across burst expiry.
    sum = 0;
    din[2] = 8'd5;
    for (int k = 0; k < 6; k++) step(4'b0100, 4'b0100, k != 3);
    step(4'b0000, 4'b0000, 1'b0);
    #1 chk("sum_sole", sum, 30);
    @(negedge clk);

    rst_pulse();

    // Priority order from ptr=0, then rotation past the burst.
    for (int k = 0; k < 4; k++) step(4'b1010, 4'b0010, k != 3);
    for (int k = 0; k < 4; k++) step(4'b1010, 4'b1000, k != 3);

    // Owner drop mid-burst: same-cycle handover, no bubble.
    step(4'b0010, 4'b0010, 1'b1);
    step(4'b0010, 4'b0010, 1'b1);
    step(4'b1000, 4'b1000, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);

    // Reset mid-burst, then first grant restarts from ptr=0.
    din[2] = 8'd7;
    for (int k = 0; k < 3; k++) step(4'b0100, 4'b0100, 1'b1);
    rst_pulse();
    step(4'b0101, 4'b0001, 1'b1);
    step(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    #1 chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
